// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and its branch-target LUT.
// Holds the sequencer state encoding and common sizing constants.
package Definitions;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int LUT_D_DEF = 16;
    localparam int LUT_IDX_W = $clog2(LUT_D_DEF);
    localparam logic [15:0] CYCLE_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target register file: split lo/hi byte writes,
// asynchronous read, synchronous clear on reset.
module branch_lut
    import Definitions::*;
#(
    parameter int PC_W  = 10,
    parameter int LUT_D = 16,
    parameter int IDX_W = $clog2(LUT_D)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             load_hi,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [PC_W-1:0]  rdata
);

    logic [PC_W-1:0] mem [LUT_D];

    // Read is combinational, so a same-cycle write is seen only next cycle.
    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_D; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            if (load_hi) begin
                mem[idx][PC_W-1:8] <= wdata[PC_W-9:0];
            end else begin
                mem[idx][7:0] <= wdata;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program sequencer: PC, Start/Done framing, next-PC mux
// and a saturating executed-cycle counter.
module fetch_unit
    import Definitions::*;
#(
    parameter int PC_W  = 10,
    parameter int LUT_D = 16
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic [PC_W-1:0]          Start_Addr,
    input  logic                     PC_Jmp_Flag,
    input  logic                     PC_Beq_Flag,
    input  logic                     LUT_Write_En,
    input  logic                     LUT_Load_Hi,
    input  logic                     LUT_Read_En,
    input  logic [$clog2(LUT_D)-1:0] Lut_Idx,
    input  logic [7:0]               Lut_Data,
    input  logic                     Ack,
    output logic [PC_W-1:0]          Prog_Addr,
    output logic                     Instr_Valid,
    output logic                     Done,
    output logic [15:0]              Cycle_Count
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] lut_target;
    logic [15:0]     cnt;
    logic            lut_we;
    logic            take;

    assign lut_we = LUT_Write_En && (state == RUN);

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_D (LUT_D)
    ) u_lut (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we      (lut_we),
        .load_hi (LUT_Load_Hi),
        .idx     (Lut_Idx),
        .wdata   (Lut_Data),
        .rdata   (lut_target)
    );

    assign take = (PC_Jmp_Flag || PC_Beq_Flag) && LUT_Read_En;

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (Ack) begin
            next_pc = pc;
        end else if (take) begin
            next_pc = lut_target;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        state <= RUN;
                        pc    <= Start_Addr;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    pc <= next_pc;
                    if (cnt != CYCLE_CNT_MAX) begin
                        cnt <= cnt + 16'd1;
                    end
                    if (Ack) begin
                        state <= HALT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Prog_Addr   = pc;
    assign Instr_Valid = (state == RUN);
    assign Done        = (state == HALT);
    assign Cycle_Count = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle model pushes
// expected outputs, the DUT result is popped and compared.
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic [9:0] Start_Addr = '0;
    logic       PC_Jmp_Flag = 1'b0;
    logic       PC_Beq_Flag = 1'b0;
    logic       LUT_Write_En = 1'b0;
    logic       LUT_Load_Hi = 1'b0;
    logic       LUT_Read_En = 1'b0;
    logic [3:0] Lut_Idx = '0;
    logic [7:0] Lut_Data = '0;
    logic       Ack = 1'b0;
    logic [9:0] Prog_Addr;
    logic       Instr_Valid;
    logic       Done;
    logic [15:0] Cycle_Count;

    fetch_unit #(.PC_W(10), .LUT_D(16)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Start_Addr   (Start_Addr),
        .PC_Jmp_Flag  (PC_Jmp_Flag),
        .PC_Beq_Flag  (PC_Beq_Flag),
        .LUT_Write_En (LUT_Write_En),
        .LUT_Load_Hi  (LUT_Load_Hi),
        .LUT_Read_En  (LUT_Read_En),
        .Lut_Idx      (Lut_Idx),
        .Lut_Data     (Lut_Data),
        .Ack          (Ack),
        .Prog_Addr    (Prog_Addr),
        .Instr_Valid  (Instr_Valid),
        .Done         (Done),
        .Cycle_Count  (Cycle_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0]  addr;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int          m_st = M_IDLE;
    logic [9:0]  m_pc = '0;
    logic [15:0] m_cnt = '0;
    logic [9:0]  m_lut [16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t       e;
        logic [9:0] nx;
        if (!Reset_n) begin
            m_st  = M_IDLE;
            m_pc  = '0;
            m_cnt = '0;
            for (int i = 0; i < 16; i++) m_lut[i] = '0;
        end else if (m_st == M_RUN) begin
            if (Ack) nx = m_pc;
            else if ((PC_Jmp_Flag || PC_Beq_Flag) && LUT_Read_En)
                nx = m_lut[Lut_Idx];
            else nx = m_pc + 10'd1;
            if (LUT_Write_En) begin
                if (LUT_Load_Hi) m_lut[Lut_Idx][9:8] = Lut_Data[1:0];
                else m_lut[Lut_Idx][7:0] = Lut_Data;
            end
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (Ack) m_st = M_HALT;
            m_pc = nx;
        end else if (Start) begin
            m_st  = M_RUN;
            m_pc  = Start_Addr;
            m_cnt = '0;
        end
        e.addr  = m_pc;
        e.valid = (m_st == M_RUN);
        e.done  = (m_st == M_HALT);
        e.cnt   = m_cnt;
        q.push_back(e);
        @(posedge Clk);
        #1;
        e = q.pop_front();
        chk("addr", 32'(Prog_Addr), 32'(e.addr));
        chk("valid", 32'(Instr_Valid), 32'(e.valid));
        chk("done", 32'(Done), 32'(e.done));
        chk("count", 32'(Cycle_Count), 32'(e.cnt));
    endtask

    task automatic lut_wr(input logic [3:0] idx, input logic hi,
                          input logic [7:0] d);
        LUT_Write_En = 1'b1;
        LUT_Load_Hi  = hi;
        Lut_Idx      = idx;
        Lut_Data     = d;
        tick();
        LUT_Write_En = 1'b0;
        LUT_Load_Hi  = 1'b0;
    endtask

    task automatic jump(input logic [3:0] idx);
        PC_Jmp_Flag = 1'b1;
        LUT_Read_En = 1'b1;
        Lut_Idx     = idx;
        tick();
        PC_Jmp_Flag = 1'b0;
        LUT_Read_En = 1'b0;
    endtask

    initial begin
        logic [9:0] p;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
        @(posedge Clk);
        #1;
        tick();
        tick();
        chk("rst_addr", 32'(Prog_Addr), 32'h0);
        chk("rst_valid", 32'(Instr_Valid), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_cnt", 32'(Cycle_Count), 32'h0);
        Reset_n = 1'b1;
        tick();

        Start = 1'b1; Start_Addr = 10'h020;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("seq", 32'(Prog_Addr), 32'h20 + 32'(i));
            tick();
        end
        chk("cnt5", 32'(Cycle_Count), 32'd5);

        lut_wr(4'd3, 1'b0, 8'h34);
        lut_wr(4'd3, 1'b1, 8'h01);
        jump(4'd3);
        chk("jmp134", 32'(Prog_Addr), 32'h134);
        LUT_Read_En = 1'b1;
        tick();
        chk("re_only", 32'(Prog_Addr), 32'h135);
        PC_Beq_Flag = 1'b1; Lut_Idx = 4'd3;
        tick();
        chk("beq", 32'(Prog_Addr), 32'h134);
        LUT_Read_En = 1'b0;
        tick();
        chk("beq_nore", 32'(Prog_Addr), 32'h135);
        PC_Jmp_Flag = 1'b1; LUT_Read_En = 1'b1;
        tick();
        chk("jmp_beq", 32'(Prog_Addr), 32'h134);
        PC_Jmp_Flag = 1'b0; PC_Beq_Flag = 1'b0; LUT_Read_En = 1'b0;

        lut_wr(4'd9, 1'b1, 8'hFE);
        jump(4'd9);
        chk("hi_excess", 32'(Prog_Addr), 32'h200);

        Start = 1'b1; Start_Addr = 10'h3FF;
        tick();
        Start = 1'b0;
        chk("start_run", 32'(Prog_Addr), 32'h201);

        lut_wr(4'd7, 1'b0, 8'h45);
        jump(4'd7);
        chk("at45", 32'(Prog_Addr), 32'h045);
        Ack = 1'b1; PC_Jmp_Flag = 1'b1; LUT_Read_En = 1'b1;
        Lut_Idx = 4'd3;
        tick();
        Ack = 1'b0; PC_Jmp_Flag = 1'b0; LUT_Read_En = 1'b0;
        chk("halt_done", 32'(Done), 32'h1);
        chk("halt_valid", 32'(Instr_Valid), 32'h0);
        chk("halt_addr", 32'(Prog_Addr), 32'h045);
        p = Cycle_Count[9:0];
        lut_wr(4'd7, 1'b0, 8'hFF);
        tick();
        chk("halt_cnt", 32'(Cycle_Count), 32'(p));

        Start = 1'b1; Start_Addr = 10'h3FF;
        tick();
        Start = 1'b0;
        chk("restart_cnt", 32'(Cycle_Count), 32'h0);
        tick();
        chk("wrap", 32'(Prog_Addr), 32'h000);
        jump(4'd7);
        chk("halt_wr_drop", 32'(Prog_Addr), 32'h045);

        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        Start = 1'b1; Start_Addr = 10'h000;
        tick();
        Start = 1'b0;
        chk("run0_addr", 32'(Prog_Addr), 32'h0);
        chk("run0_cnt", 32'(Cycle_Count), 32'h0);
        tick();
        tick();

        Reset_n = 1'b0; Start = 1'b1; Start_Addr = 10'h155;
        tick();
        chk("mrst_addr", 32'(Prog_Addr), 32'h0);
        chk("mrst_valid", 32'(Instr_Valid), 32'h0);
        chk("mrst_cnt", 32'(Cycle_Count), 32'h0);
        Reset_n = 1'b1; Start = 1'b0;
        tick();
        Start = 1'b1; Start_Addr = 10'h100;
        tick();
        Start = 1'b0;
        jump(4'd3);
        chk("lut_cleared", 32'(Prog_Addr), 32'h0);

        lut_wr(4'd5, 1'b0, 8'h10);
        LUT_Write_En = 1'b1; LUT_Load_Hi = 1'b0; Lut_Data = 8'hAA;
        PC_Jmp_Flag = 1'b1; LUT_Read_En = 1'b1; Lut_Idx = 4'd5;
        tick();
        LUT_Write_En = 1'b0;
        chk("war_old", 32'(Prog_Addr), 32'h010);
        tick();
        chk("war_new", 32'(Prog_Addr), 32'h0AA);
        PC_Jmp_Flag = 1'b0; LUT_Read_En = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program sequencer on the other end of the control decoder's PC and LUT interface. It holds the program counter and the 16-entry branch-target LUT, and drives the instruction-memory address. It also consumes the decoder's `PC_Jmp_Flag`, `PC_Beq_Flag`, `LUT_Write_En`, `LUT_Load_Hi`, `LUT_Read_En` and `Ack`. It frames each program run with a Start/Done handshake and counts executed cycles.

## Interface
- `PC_W`, default 10: program counter / instruction address width; legal range 9–16.
- `LUT_D`, default 16: branch LUT depth; index width is log2(`LUT_D`).
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset_n` in 1: one clock; reset is synchronous and active-low.
- `Start` in 1: begin a run; sampled in IDLE or HALT.
- `Start_Addr` in `PC_W`: first instruction address, captured when `Start` is accepted.
- `PC_Jmp_Flag` in 1: unconditional jump to `LUT[Lut_Idx]`.
- `PC_Beq_Flag` in 1: branch taken (condition already resolved upstream).
- `LUT_Write_En` in 1: write one LUT half.
- `LUT_Load_Hi` in 1: 0 = write bits [7:0]; 1 = write bits [`PC_W`-1:8].
- `LUT_Read_En` in 1: LUT read qualifier for jump/branch.
- `Lut_Idx` in log2(`LUT_D`): LUT index, i.e. `Instruction[3:0]`.
- `Lut_Data` in 8: write data (accumulator value).
- `Ack` in 1: HLT decoded.
- `Prog_Addr` out `PC_W`: current PC, driving the asynchronous-read instruction ROM.
- `Instr_Valid` out 1: high in RUN; gates the decoder's write enables externally.
- `Done` out 1: high in HALT.
- `Cycle_Count` out 16: instructions executed in the current or last run; saturates at 16'hFFFF.

## Operation
- States:
  - **IDLE**: after reset.
  - **RUN**: executing.
  - **HALT**: finished.
- Transitions:
  - IDLE→RUN on `Start`; PC←`Start_Addr`, `Cycle_Count`←0.
  - RUN→HALT when `Ack`=1; PC holds at the HLT address.
  - HALT→RUN on `Start`, with the same loads as IDLE→RUN.
  - `Start` in RUN is ignored.
- Next-PC in RUN, in priority order:
  - `Ack` → hold.
  - `PC_Jmp_Flag & LUT_Read_En` → `LUT[Lut_Idx]`.
  - `PC_Beq_Flag & LUT_Read_En` → `LUT[Lut_Idx]`.
  - Otherwise → PC+1, modulo 2^`PC_W` (all-ones wraps to 0).
  - Jmp and Beq asserted together → jump (same target).
  - Jmp or Beq without `LUT_Read_En` → PC+1.
- LUT write happens in RUN only; writes in IDLE or HALT are dropped.
  - Lo write replaces bits [7:0] and leaves the upper bits unchanged.
  - Hi write replaces bits [`PC_W`-1:8] with `Lut_Data[PC_W-9:0]`; excess bits are ignored.
- Same-cycle LUT write and read of the same index: the read returns the pre-write value (write-after-read).
- `Cycle_Count` increments once per RUN cycle, including the HLT cycle, and saturates. It holds in HALT and IDLE.
- Reset (synchronous, `Reset_n`=0 at an edge), valid in any state including mid-run:
  - state←IDLE, PC←0, every LUT entry←0, `Cycle_Count`←0.
  - `Reset_n`=0 overrides `Start` in the same cycle.

## Timing
- Reset values: `Prog_Addr`=0, `Instr_Valid`=0, `Done`=0, `Cycle_Count`=0.
- `Start` accepted at edge N: `Instr_Valid`=1 and `Prog_Addr`=`Start_Addr` in cycle N+1.
- One instruction per cycle. Branch and jump take effect at the next edge: zero bubbles, no delay slot.
- `Ack` in cycle N: `Done`=1 and `Instr_Valid`=0 from cycle N+1; `Prog_Addr` is unchanged.
- All outputs are registered or decoded from registered state only. No combinational input→output path.
- LUT written at edge N is readable from cycle N+1.

## Structure
- Add to the shared `Definitions` package:
  - `fetch_state_t` enum {IDLE, RUN, HALT}.
  - `LUT_IDX_W` constant.
  - A `CYCLE_CNT_MAX` constant.
- Sub-module `branch_lut`: the `LUT_D` × `PC_W` register array with split lo/hi byte write, asynchronous read and synchronous clear on reset.
- The top level holds the FSM, the next-PC mux and the counter. Expected RTL size is 150–250 lines.

## Test plan
- Reset then `Start` with `Start_Addr`=10'h020, no flags for 5 cycles → `Prog_Addr` 020,021,022,023,024; `Cycle_Count`=5.
- LUT[3] lo=8'h34 and hi=8'h01, then `PC_Jmp_Flag`, `LUT_Read_En`, `Lut_Idx`=3 → next `Prog_Addr`=10'h134. With `PC_Beq_Flag`=0 and `LUT_Read_En`=1 → PC+1.
- `Start_Addr`=10'h3FF with no flags → next `Prog_Addr`=10'h000.
- `Ack` at PC=10'h045 → `Done`=1, `Instr_Valid`=0, `Prog_Addr` stays 045. A second `Start` with addr 0 → RUN from 0 and `Cycle_Count` restarts at 0.
- Mid-run `Reset_n`=0 for one cycle while `Start`=1 → IDLE, PC=0, LUT[3] reads 0, all outputs at reset values.
- Same-cycle lo write of 8'hAA to LUT[5] and jump via LUT[5] (old value 10'h010) → PC=10'h010; the next jump via LUT[5] → 10'h0AA.
